gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
- Wishbone-slave GPIO controller for up to 32 bidirectional pins. Each pin connects externally to one IOBUF instance.
- Holds the direction and output registers and synchronises pad inputs.
- Detects per-pin edges and raises a level interrupt to the core.
- Sits on the SoC peripheral bus next to UART/timer.

Parameters:
N, 32, number of GPIO pins (1..32); register bits at index N and above read 0 and ignore writes.
SYNC_STAGES, 2, flop stages on gpio_in_i before any use (>=2).

Ports:
clk_i  input  1  system clock.
rst_i  input  1  asynchronous active-high reset.
wb_cyc_i  input  1  Wishbone cycle.
wb_stb_i  input  1  Wishbone strobe.
wb_we_i  input  1  1=write, 0=read.
wb_adr_i  input  3  word address (byte address bits [4:2]).
wb_dat_i  input  32  write data.
wb_sel_i  input  4  byte lane enables.
wb_dat_o  output  32  read data, valid with ack.
wb_ack_o  output  1  transfer acknowledge.
gpio_dir_o  output  N  per-pin direction to IOBUF (1=input/hi-Z, 0=drive).
gpio_out_o  output  N  per-pin output value to IOBUF.
gpio_in_i  input  N  per-pin value read back from IOBUF (asynchronous).
irq_o  output  1  interrupt, active-high level.

Behaviour:
- Register map (word address : name : access):
  - 0 IN: RO, synchronised input.
  - 1 OUT: RW.
  - 2 DIR: RW, 1=input.
  - 3 OUT_SET: WO, write-1 sets OUT bits; reads 0.
  - 4 OUT_CLR: WO, write-1 clears OUT bits; reads 0.
  - 5 IE: RW, interrupt enable.
  - 6 IP: RW1C, pending edges.
  - 7 EDGE: RW, 0=rising, 1=falling.
- Reset values:
  - DIR = all 1s, so every pin is hi-Z at power-up.
  - OUT, IE, IP, EDGE = 0.
  - Sync flops = 0.
  - wb_ack_o = 0, wb_dat_o = 0, irq_o = 0.
- Handshake:
  - wb_ack_o rises one cycle after a cycle with cyc&stb&!ack, and holds for exactly one cycle.
  - A held strobe produces an ack every other cycle (1 wait state).
  - No bus errors; every address acks.
- Writes commit on the clock edge that raises ack.
  - Byte lanes honour wb_sel_i; for SET/CLR/IP, lanes not selected act as 0.
- Reads: wb_dat_o is registered on the same edge as ack and holds its value until the next ack.
- Input path:
  - gpio_in_i passes through SYNC_STAGES flops to produce in_s; one further flop produces in_d.
  - IN reads in_s, for every pin regardless of DIR.
  - Latency: a pad change is visible in IN SYNC_STAGES cycles later.
- Outputs: gpio_dir_o = DIR and gpio_out_o = OUT, driven directly from the registers. They change on the cycle after the write edge.
- Edge detect:
  - Per bit, edge = EDGE ? (in_d & ~in_s) : (~in_d & in_s).
  - An edge sets IP[i]. Edges are detected on all pins, including outputs, so loopback is observable.
- IP update per bit: next = (IP & ~w1c_mask) | edge. A set in the same cycle as a clear wins; no event is lost.
- irq_o is registered: irq_o <= |(IP & IE), one cycle after IP/IE update.
- Simultaneous OUT write and SET/CLR cannot occur (one transfer per ack).
- Reset asserted mid-transfer drops ack immediately and discards the write. Master retry is required.
- cyc low aborts: no ack is generated, and an ack already registered still completes its single cycle.

Test Plan:
- Reset values: assert rst_i async mid-cycle -> gpio_dir_o=0xFFFFFFFF, gpio_out_o=0, irq_o=0; read DIR -> 0xFFFFFFFF with ack exactly 1 cycle after stb.
- Output control: write OUT=0x0000A5A5, then OUT_SET=0x00010000, OUT_CLR=0x00000005 -> gpio_out_o=0x0001A5A0. Write DIR=0xFFFF0000 -> gpio_dir_o=0xFFFF0000. Write OUT with sel=0b0010, data 0xFFFFFFFF -> gpio_out_o=0x0001FFA0.
- Input sync: toggle gpio_in_i[3] 0->1 -> IN[3] reads 1 no earlier than 2 cycles after the change. Set IE=0x8 with EDGE=0 -> IP=0x8 and irq_o=1 one cycle after the IP set.
- W1C vs edge race: with IP[3]=1, write IP=0x8 in the same cycle a new rising edge sets bit 3 -> IP[3] stays 1. A write with no edge -> IP=0 and irq_o drops the next cycle.
- Falling-edge mode: EDGE=0x1, gpio_in_i[0] 1->0 -> IP=0x1. A subsequent 0->1 leaves IP unchanged; IE=0 keeps irq_o=0.
- N=8 instance: write 0xFFFFFFFF to OUT -> read 0x000000FF. Reads of OUT_SET/OUT_CLR return 0.

Source files
------------

// File: rtl/gpio_ctrl.sv
// Wishbone-slave GPIO controller: direction/output registers, synchronised
// pad inputs, per-pin edge capture and a level interrupt.
module gpio_ctrl #(
    parameter int N           = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wb_cyc_i,
    input  logic         wb_stb_i,
    input  logic         wb_we_i,
    input  logic [2:0]   wb_adr_i,
    input  logic [31:0]  wb_dat_i,
    input  logic [3:0]   wb_sel_i,
    output logic [31:0]  wb_dat_o,
    output logic         wb_ack_o,
    output logic [N-1:0] gpio_dir_o,
    output logic [N-1:0] gpio_out_o,
    input  logic [N-1:0] gpio_in_i,
    output logic         irq_o
);

    localparam logic [2:0] ADR_IN      = 3'd0;
    localparam logic [2:0] ADR_OUT     = 3'd1;
    localparam logic [2:0] ADR_DIR     = 3'd2;
    localparam logic [2:0] ADR_OUT_SET = 3'd3;
    localparam logic [2:0] ADR_OUT_CLR = 3'd4;
    localparam logic [2:0] ADR_IE      = 3'd5;
    localparam logic [2:0] ADR_IP      = 3'd6;
    localparam logic [2:0] ADR_EDGE    = 3'd7;

    logic         r_ack;
    logic [31:0]  r_dat;
    logic         r_irq;
    logic [N-1:0] r_out;
    logic [N-1:0] r_dir;
    logic [N-1:0] r_ie;
    logic [N-1:0] r_ip;
    logic [N-1:0] r_edge;
    logic [N-1:0] r_inD;
    logic [N-1:0] r_sync [SYNC_STAGES];

    logic         w_req;
    logic         w_wr;
    logic [31:0]  w_laneMask;
    logic [31:0]  w_wdat;
    logic [31:0]  w_rdata;
    logic [N-1:0] w_wmask;
    logic [N-1:0] w_wbits;
    logic [N-1:0] w_w1c;
    logic [N-1:0] w_inS;
    logic [N-1:0] w_edge;

    // The !ack term gives one wait state between back-to-back strobes.
    assign w_req      = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr       = w_req & wb_we_i;
    assign w_laneMask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                         {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign w_wdat     = wb_dat_i & w_laneMask;
    assign w_wmask    = w_laneMask[N-1:0];
    assign w_wbits    = w_wdat[N-1:0];
    assign w_w1c      = (w_wr && wb_adr_i == ADR_IP) ? w_wbits : '0;

    assign w_inS  = r_sync[SYNC_STAGES-1];
    assign w_edge = (r_edge & r_inD & ~w_inS) | (~r_edge & ~r_inD & w_inS);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_inD <= '0;
        end else begin
            r_sync[0] <= gpio_in_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_inD <= w_inS;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack  <= 1'b0;
            r_dat  <= '0;
            r_out  <= '0;
            r_dir  <= '1;
            r_ie   <= '0;
            r_edge <= '0;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_dat <= w_rdata;
            end
            if (w_wr) begin
                case (wb_adr_i)
                    ADR_OUT:     r_out  <= (r_out & ~w_wmask) | w_wbits;
                    ADR_DIR:     r_dir  <= (r_dir & ~w_wmask) | w_wbits;
                    ADR_OUT_SET: r_out  <= r_out | w_wbits;
                    ADR_OUT_CLR: r_out  <= r_out & ~w_wbits;
                    ADR_IE:      r_ie   <= (r_ie & ~w_wmask) | w_wbits;
                    ADR_EDGE:    r_edge <= (r_edge & ~w_wmask) | w_wbits;
                    default:     ;
                endcase
            end
        end
    end

    // A new edge in the same cycle as a W1C keeps the pending bit set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ip  <= '0;
            r_irq <= 1'b0;
        end else begin
            r_ip  <= (r_ip & ~w_w1c) | w_edge;
            r_irq <= |(r_ip & r_ie);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (wb_adr_i)
            ADR_IN:   w_rdata = 32'(w_inS);
            ADR_OUT:  w_rdata = 32'(r_out);
            ADR_DIR:  w_rdata = 32'(r_dir);
            ADR_IE:   w_rdata = 32'(r_ie);
            ADR_IP:   w_rdata = 32'(r_ip);
            ADR_EDGE: w_rdata = 32'(r_edge);
            default:  w_rdata = '0;
        endcase
    end

    assign wb_ack_o   = r_ack;
    assign wb_dat_o   = r_dat;
    assign irq_o      = r_irq;
    assign gpio_dir_o = r_dir;
    assign gpio_out_o = r_out;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: a 32-pin and an 8-pin instance share one
// bus; expectations come from a register-level model of the GPIO block.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [2:0]  adr;
    logic [31:0] datI;
    logic [3:0]  sel;
    logic [31:0] datO, dat8O;
    logic        ack, ack8;
    logic [31:0] dirO, outO;
    logic [7:0]  dir8O, out8O;
    logic [31:0] pad;
    logic [7:0]  pad8;
    logic        irq, irq8;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_out, m_dir, m_ie, m_ip, m_edge;

    always #5 clk = ~clk;
    assign pad8 = pad[7:0];

    gpio_ctrl #(.N(32), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(datI), .wb_sel_i(sel), .wb_dat_o(datO),
        .wb_ack_o(ack), .gpio_dir_o(dirO), .gpio_out_o(outO), .gpio_in_i(pad),
        .irq_o(irq)
    );

    gpio_ctrl #(.N(8), .SYNC_STAGES(2)) dut8 (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(datI), .wb_sel_i(sel), .wb_dat_o(dat8O),
        .wb_ack_o(ack8), .gpio_dir_o(dir8O), .gpio_out_o(out8O), .gpio_in_i(pad8),
        .irq_o(irq8)
    );

    function automatic logic [31:0] lanes(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // Pins that made the transition selected by the edge mode of each pin.
    function automatic logic [31:0] edgesOf(input logic [31:0] oldV, input logic [31:0] newV,
                                            input logic [31:0] mode);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            if (mode[i]) r[i] = oldV[i] && !newV[i];
            else         r[i] = !oldV[i] && newV[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] expRead(input logic [2:0] a);
        case (a)
            3'd0: return pad;
            3'd1: return m_out;
            3'd2: return m_dir;
            3'd5: return m_ie;
            3'd6: return m_ip;
            3'd7: return m_edge;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic expIrq();
        return (m_ip & m_ie) != 0;
    endfunction

    task automatic modelReset();
        m_out = 0; m_dir = 32'hFFFF_FFFF; m_ie = 0; m_ip = 0; m_edge = 0;
    endtask

    task automatic xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic [31:0] rd8);
        int lat;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; datI = d; sel = s;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!ack && lat < 10);
        checks++;
        if (ack !== 1'b1 || ack8 !== 1'b1 || lat != 1) begin
            errors++;
            $display("[TB] FAIL ack_latency adr=%0d actual=%0d required=1 (ack8=%b)", a, lat, ack8);
        end
        rd = datO; rd8 = dat8O;
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic doWrite(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd, rd8, wb, ln;
        xfer(1'b1, a, d, s, rd, rd8);
        ln = lanes(s);
        wb = d & ln;
        case (a)
            3'd1: m_out  = (m_out & ~ln) | wb;
            3'd2: m_dir  = (m_dir & ~ln) | wb;
            3'd3: m_out  = m_out | wb;
            3'd4: m_out  = m_out & ~wb;
            3'd5: m_ie   = (m_ie & ~ln) | wb;
            3'd6: m_ip   = m_ip & ~wb;
            3'd7: m_edge = (m_edge & ~ln) | wb;
            default: ;
        endcase
    endtask

    task automatic readCheck(input logic [2:0] a, input string name);
        logic [31:0] rd, rd8, e;
        xfer(1'b0, a, 32'h0, 4'hF, rd, rd8);
        e = expRead(a);
        checks++;
        if (rd !== e) begin
            errors++;
            $display("[TB] FAIL %s read32 actual=%h required=%h", name, rd, e);
        end
        checks++;
        if (rd8 !== (e & 32'hFF)) begin
            errors++;
            $display("[TB] FAIL %s read8 actual=%h required=%h", name, rd8, e & 32'hFF);
        end
    endtask

    task automatic setPads(input logic [31:0] v);
        @(negedge clk);
        m_ip = m_ip | edgesOf(pad, v, m_edge);
        pad = v;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic checkPins(input string name);
        checks++;
        if (outO !== m_out || out8O !== m_out[7:0]) begin
            errors++;
            $display("[TB] FAIL %s gpio_out actual=%h/%h required=%h", name, outO, out8O, m_out);
        end
        checks++;
        if (dirO !== m_dir || dir8O !== m_dir[7:0]) begin
            errors++;
            $display("[TB] FAIL %s gpio_dir actual=%h/%h required=%h", name, dirO, dir8O, m_dir);
        end
    endtask

    task automatic checkIrq(input string name, input logic e);
        checks++;
        if (irq !== e) begin
            errors++;
            $display("[TB] FAIL %s irq actual=%b required=%b", name, irq, e);
        end
    endtask

    task automatic test_reset();
        modelReset();
        checkPins("reset_pins");
        checkIrq("reset_irq", 1'b0);
        readCheck(3'd2, "reset_dir");
        doWrite(3'd1, 32'h1234_5678, 4'hF);
        doWrite(3'd2, 32'h0, 4'hF);
        checkPins("pre_async_reset");
        // Reset asserted in the middle of a transfer's ack cycle.
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = 3'd1; datI = 32'hDEAD_BEEF; sel = 4'hF;
        @(posedge clk); #3;
        rst = 1;
        #1;
        modelReset();
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_ack actual=%b required=0", ack);
        end
        checkPins("async_reset");
        checkIrq("async_reset_irq", 1'b0);
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
        rst = 0;
        readCheck(3'd1, "after_reset_out");
    endtask

    task automatic test_output();
        doWrite(3'd1, 32'h0000_A5A5, 4'hF);
        doWrite(3'd3, 32'h0001_0000, 4'hF);
        doWrite(3'd4, 32'h0000_0005, 4'hF);
        checks++;
        if (outO !== 32'h0001_A5A0) begin
            errors++;
            $display("[TB] FAIL out_set_clr actual=%h required=0001a5a0", outO);
        end
        doWrite(3'd2, 32'hFFFF_0000, 4'hF);
        checkPins("dir_write");
        doWrite(3'd1, 32'hFFFF_FFFF, 4'b0010);
        checks++;
        if (outO !== 32'h0001_FFA0) begin
            errors++;
            $display("[TB] FAIL out_byte_lane actual=%h required=0001ffa0", outO);
        end
        for (int k = 0; k < 12; k++) begin
            logic [2:0] a;
            a = 3'($urandom_range(1, 4));
            doWrite(a, $urandom, 4'($urandom));
            checkPins("random_out");
            readCheck(3'($urandom_range(1, 2)), "random_readback");
        end
        readCheck(3'd3, "read_out_set");
        readCheck(3'd4, "read_out_clr");
    endtask

    task automatic test_n8();
        logic [31:0] rd, rd8;
        doWrite(3'd1, 32'hFFFF_FFFF, 4'hF);
        xfer(1'b0, 3'd1, 32'h0, 4'hF, rd, rd8);
        checks++;
        if (rd8 !== 32'h0000_00FF || rd !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL n8_out_read actual=%h/%h required=000000ff/ffffffff", rd8, rd);
        end
        readCheck(3'd3, "n8_out_set");
        readCheck(3'd4, "n8_out_clr");
    endtask

    task automatic test_input_sync();
        setPads(32'h0);
        doWrite(3'd7, 32'h0, 4'hF);
        doWrite(3'd6, 32'hFFFF_FFFF, 4'hF);
        doWrite(3'd5, 32'h8, 4'hF);
        // Pad changes just after an edge; a read acked on the next edge must still see 0.
        @(posedge clk); #2;
        pad = 32'h8;
        m_ip = m_ip | 32'h8;
        begin
            logic [31:0] rd, rd8;
            xfer(1'b0, 3'd0, 32'h0, 4'hF, rd, rd8);
            checks++;
            if (rd[3] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL in_sync_early actual=%b required=0", rd[3]);
            end
            xfer(1'b0, 3'd0, 32'h0, 4'hF, rd, rd8);
            checks++;
            if (rd[3] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL in_sync_late actual=%b required=1", rd[3]);
            end
        end
        repeat (3) @(posedge clk);
        readCheck(3'd6, "ip_rise");
        checkIrq("irq_rise", 1'b1);
        // irq timing: IN after 2 edges, IP on the 3rd, irq on the 4th.
        setPads(32'h0);
        doWrite(3'd6, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #2;
        pad = 32'h8;
        m_ip = m_ip | 32'h8;
        repeat (3) @(posedge clk);
        #1;
        checkIrq("irq_before_latency", 1'b0);
        @(posedge clk); #1;
        checkIrq("irq_latency", 1'b1);
        for (int k = 0; k < 4; k++) begin
            setPads($urandom);
            readCheck(3'd0, "random_in");
        end
    endtask

    task automatic test_w1c_race();
        doWrite(3'd7, 32'h0, 4'hF);
        doWrite(3'd5, 32'h8, 4'hF);
        setPads(32'h0);
        doWrite(3'd6, 32'hFFFF_FFFF, 4'hF);
        setPads(32'h8);
        setPads(32'h0);
        readCheck(3'd6, "race_setup_ip");
        // Rising edge reaches the detector exactly on the W1C commit edge.
        @(posedge clk); #2;
        pad = 32'h8;
        @(posedge clk);
        @(posedge clk);
        doWrite(3'd6, 32'h8, 4'hF);
        m_ip = m_ip | 32'h8;
        readCheck(3'd6, "race_ip_kept");
        doWrite(3'd6, 32'h8, 4'hF);
        checkIrq("irq_before_drop", 1'b1);
        @(posedge clk); #1;
        checkIrq("irq_drop", 1'b0);
        readCheck(3'd6, "ip_cleared");
    endtask

    task automatic test_falling_edge();
        doWrite(3'd5, 32'h0, 4'hF);
        doWrite(3'd7, 32'h1, 4'hF);
        setPads(32'h1);
        doWrite(3'd6, 32'hFFFF_FFFF, 4'hF);
        setPads(32'h0);
        readCheck(3'd6, "fall_ip_set");
        setPads(32'h1);
        readCheck(3'd6, "fall_ip_unchanged");
        checkIrq("fall_irq_masked", 1'b0);
    endtask

    task automatic test_random_irq();
        for (int k = 0; k < 5; k++) begin
            doWrite(3'd7, $urandom, 4'hF);
            doWrite(3'd5, $urandom, 4'($urandom));
            for (int j = 0; j < 3; j++) begin
                setPads($urandom);
                checkIrq("random_irq", expIrq());
            end
            readCheck(3'd6, "random_ip");
            readCheck(3'd5, "random_ie");
            readCheck(3'd7, "random_edge");
            doWrite(3'd6, $urandom, 4'($urandom));
            repeat (2) @(posedge clk);
            #1;
            checkIrq("random_irq_after_w1c", expIrq());
            readCheck(3'd6, "random_ip_after_w1c");
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 3'd2; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ack !== ((i % 2) == 0)) begin
                errors++;
                $display("[TB] FAIL held_strobe_ack cycle=%0d actual=%b required=%b", i, ack, (i % 2) == 0);
            end
        end
        @(negedge clk);
        cyc = 0; stb = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("[TB] FAIL cyc_low_ack cycle=%0d actual=%b required=0", i, ack);
            end
        end
        @(negedge clk);
        stb = 0;
    endtask

    initial begin
        rst = 1; cyc = 0; stb = 0; we = 0; adr = 0; datI = 0; sel = 0; pad = 0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        test_reset();
        test_output();
        test_n8();
        test_input_sync();
        test_w1c_race();
        test_falling_edge();
        test_random_irq();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
